// File: rtl/fsk_pkg.sv
// fsk_pkg
// Shared types and constants for the FSK receive controller and the
// demodulator bench: controller state encoding, interval-counter ceiling,
// reset threshold values and the threshold derivation helper.
package fsk_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAL_ARM = 3'd1,
        CAL     = 3'd2,
        CALC    = 3'd3,
        HUNT    = 3'd4,
        LOCK    = 3'd5
    } state_t;

    localparam logic [15:0] IC_MAX      = 16'hFFFF;

    // With v_short=0 and v_long=FFFF the demodulator never sees a valid
    // interval and holds its output.
    localparam logic [15:0] V_SHORT_RST = 16'h0000;
    localparam logic [15:0] V_LONG_RST  = 16'hFFFF;

    typedef struct packed {
        logic [15:0] v_short;
        logic [15:0] v_long;
    } thr_t;

    // Thresholds sit an eighth of the spread either side of the midpoint.
    // The sum is widened to 17 bits so min+max cannot overflow; because
    // h <= spread/2, the results always stay inside [min, max].
    function automatic thr_t calc_thresholds(input logic [15:0] lo,
                                             input logic [15:0] hi);
        logic [16:0] sum;
        logic [15:0] mid;
        logic [15:0] spread;
        logic [15:0] h;
        thr_t        res;
        spread      = hi - lo;
        sum         = {1'b0, lo} + {1'b0, hi};
        mid         = sum[16:1];
        h           = spread >> 3;
        res.v_short = mid - h;
        res.v_long  = mid + h;
        return res;
    endfunction

endpackage

// File: rtl/fsk_interval_stats.sv
// fsk_interval_stats
// Saturating edge-to-edge interval counter plus min/max/count tracker used
// during preamble calibration.
// Ports:
//   bb_clk    in   baseband clock, rising edge
//   rst       in   synchronous active-high reset
//   clear     in   reset tracker (n=0, min=FFFF, max=0); ic is unaffected
//   track     in   accept the interval sampled on edge_evt into min/max/n
//   edge_evt  in   one-cycle pulse per detected edge
//   ic        out  current interval count (cleared by edge, saturates)
//   min_val   out  smallest interval seen since clear
//   max_val   out  largest interval seen since clear
//   n         out  number of intervals accepted since clear
//   sat       out  ic has reached IC_MAX
module fsk_interval_stats
    import fsk_pkg::*;
(
    input  logic        bb_clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        track,
    input  logic        edge_evt,
    output logic [15:0] ic,
    output logic [15:0] min_val,
    output logic [15:0] max_val,
    output logic [7:0]  n,
    output logic        sat
);

    always_ff @(posedge bb_clk) begin
        if (rst) begin
            ic <= '0;
        end else if (edge_evt) begin
            ic <= '0;
        end else if (ic != IC_MAX) begin
            ic <= ic + 16'd1;
        end
    end

    // The value of ic on the edge cycle is the interval just completed.
    always_ff @(posedge bb_clk) begin
        if (rst || clear) begin
            n       <= '0;
            min_val <= IC_MAX;
            max_val <= '0;
        end else if (track && edge_evt) begin
            n <= n + 8'd1;
            if (ic < min_val) begin
                min_val <= ic;
            end
            if (ic > max_val) begin
                max_val <= ic;
            end
        end
    end

    assign sat = (ic == IC_MAX);

endmodule

// File: rtl/fsk_rx_ctrl.sv
// fsk_rx_ctrl
// Receive-side controller sequencing the FSK demodulator: calibrates the
// v_short/v_long thresholds from preamble edge intervals, then hunts for the
// sync word in the demodulated bit stream and frames the payload.
// Ports:
//   bb_clk        in   baseband clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   pulse: leave IDLE and begin calibration
//   stop          in   pulse: return to IDLE from any state
//   edge_evt      in   one-cycle pulse per flag_bit edge
//   bit_in        in   demodulated bit
//   bit_vld       in   qualifies bit_in
//   v_short       out  short-interval threshold
//   v_long        out  long-interval threshold
//   cal_done      out  level: thresholds valid
//   cal_err       out  pulse: calibration rejected (spread too small)
//   frame_sync    out  pulse: sync word matched
//   pay_bit       out  payload bit
//   pay_vld       out  qualifies pay_bit
//   frame_done    out  pulse with the last payload bit
//   carrier_lost  out  pulse on interval timeout
module fsk_rx_ctrl
    import fsk_pkg::*;
#(
    parameter int                  CAL_N        = 16,
    parameter int                  MIN_SPREAD   = 8,
    parameter int                  SYNC_W       = 16,
    parameter logic [SYNC_W-1:0]   SYNC_WORD    = 16'h2DD4,
    parameter int                  PAYLOAD_BITS = 64
)(
    input  logic        bb_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        edge_evt,
    input  logic        bit_in,
    input  logic        bit_vld,
    output logic [15:0] v_short,
    output logic [15:0] v_long,
    output logic        cal_done,
    output logic        cal_err,
    output logic        frame_sync,
    output logic        pay_bit,
    output logic        pay_vld,
    output logic        frame_done,
    output logic        carrier_lost
);

    localparam int SC_W = $clog2(SYNC_W + 1);

    state_t              state, state_n;
    logic [15:0]         v_short_n, v_long_n;
    logic                cal_done_n, cal_err_n, frame_sync_n;
    logic                pay_bit_n, pay_vld_n, frame_done_n, carrier_lost_n;
    logic [SYNC_W-1:0]   sreg, sreg_n, shifted;
    logic [SC_W-1:0]     sync_cnt, sync_cnt_n;
    logic [15:0]         bit_cnt, bit_cnt_n;

    logic                stats_clear, stats_track;
    logic [15:0]         ic, min_val, max_val, spread;
    logic [7:0]          n_cnt;
    logic                sat, timeout;
    thr_t                thr;

    fsk_interval_stats u_stats (
        .bb_clk   (bb_clk),
        .rst      (rst),
        .clear    (stats_clear),
        .track    (stats_track),
        .edge_evt (edge_evt),
        .ic       (ic),
        .min_val  (min_val),
        .max_val  (max_val),
        .n        (n_cnt),
        .sat      (sat)
    );

    // The raw count is exposed by the stats block for observation; the
    // controller itself only needs the saturation flag.
    logic unused_ic;
    assign unused_ic = ^ic;

    // A coincident edge clears the counter, so it never counts as a timeout.
    assign timeout = sat && !edge_evt;
    assign spread  = max_val - min_val;
    assign thr     = calc_thresholds(min_val, max_val);
    assign shifted = {sreg[SYNC_W-2:0], bit_in};

    always_ff @(posedge bb_clk) begin
        if (rst) begin
            state        <= IDLE;
            v_short      <= V_SHORT_RST;
            v_long       <= V_LONG_RST;
            cal_done     <= 1'b0;
            cal_err      <= 1'b0;
            frame_sync   <= 1'b0;
            pay_bit      <= 1'b0;
            pay_vld      <= 1'b0;
            frame_done   <= 1'b0;
            carrier_lost <= 1'b0;
            sreg         <= '0;
            sync_cnt     <= '0;
            bit_cnt      <= '0;
        end else begin
            state        <= state_n;
            v_short      <= v_short_n;
            v_long       <= v_long_n;
            cal_done     <= cal_done_n;
            cal_err      <= cal_err_n;
            frame_sync   <= frame_sync_n;
            pay_bit      <= pay_bit_n;
            pay_vld      <= pay_vld_n;
            frame_done   <= frame_done_n;
            carrier_lost <= carrier_lost_n;
            sreg         <= sreg_n;
            sync_cnt     <= sync_cnt_n;
            bit_cnt      <= bit_cnt_n;
        end
    end

    // stop overrides every state; losing the carrier in HUNT/LOCK also
    // invalidates the thresholds so the demodulator holds its output.
    always_comb begin
        state_n        = state;
        v_short_n      = v_short;
        v_long_n       = v_long;
        cal_done_n     = cal_done;
        cal_err_n      = 1'b0;
        frame_sync_n   = 1'b0;
        pay_bit_n      = pay_bit;
        pay_vld_n      = 1'b0;
        frame_done_n   = 1'b0;
        carrier_lost_n = 1'b0;
        sreg_n         = sreg;
        sync_cnt_n     = sync_cnt;
        bit_cnt_n      = bit_cnt;
        stats_clear    = 1'b0;
        stats_track    = 1'b0;

        if (stop) begin
            state_n    = IDLE;
            cal_done_n = 1'b0;
            v_short_n  = V_SHORT_RST;
            v_long_n   = V_LONG_RST;
            sreg_n     = '0;
            sync_cnt_n = '0;
            bit_cnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = CAL_ARM;
                    end
                end

                // The first edge only opens an interval; the tracker is held
                // clear through it.
                CAL_ARM: begin
                    stats_clear = 1'b1;
                    if (edge_evt) begin
                        state_n = CAL;
                    end
                end

                CAL: begin
                    if (timeout) begin
                        carrier_lost_n = 1'b1;
                        state_n        = CAL_ARM;
                    end else begin
                        stats_track = 1'b1;
                        if (edge_evt && (n_cnt == 8'(CAL_N - 1))) begin
                            state_n = CALC;
                        end
                    end
                end

                CALC: begin
                    if (spread < 16'(MIN_SPREAD)) begin
                        cal_err_n = 1'b1;
                        state_n   = CAL_ARM;
                    end else begin
                        v_short_n  = thr.v_short;
                        v_long_n   = thr.v_long;
                        cal_done_n = 1'b1;
                        sreg_n     = '0;
                        sync_cnt_n = '0;
                        state_n    = HUNT;
                    end
                end

                // sync_cnt saturates at SYNC_W and gates the match until a
                // full word has been shifted in since entering HUNT.
                HUNT: begin
                    if (timeout) begin
                        carrier_lost_n = 1'b1;
                        cal_done_n     = 1'b0;
                        v_short_n      = V_SHORT_RST;
                        v_long_n       = V_LONG_RST;
                        sreg_n         = '0;
                        sync_cnt_n     = '0;
                        state_n        = CAL_ARM;
                    end else if (bit_vld) begin
                        sreg_n = shifted;
                        if (sync_cnt != SC_W'(SYNC_W)) begin
                            sync_cnt_n = sync_cnt + 1'b1;
                        end
                        if ((sync_cnt >= SC_W'(SYNC_W - 1)) &&
                            (shifted == SYNC_WORD)) begin
                            frame_sync_n = 1'b1;
                            bit_cnt_n    = '0;
                            state_n      = LOCK;
                        end
                    end
                end

                LOCK: begin
                    if (timeout) begin
                        carrier_lost_n = 1'b1;
                        cal_done_n     = 1'b0;
                        v_short_n      = V_SHORT_RST;
                        v_long_n       = V_LONG_RST;
                        sreg_n         = '0;
                        sync_cnt_n     = '0;
                        bit_cnt_n      = '0;
                        state_n        = CAL_ARM;
                    end else if (bit_vld) begin
                        pay_vld_n = 1'b1;
                        pay_bit_n = bit_in;
                        if (bit_cnt == 16'(PAYLOAD_BITS - 1)) begin
                            frame_done_n = 1'b1;
                            bit_cnt_n    = '0;
                            sreg_n       = '0;
                            sync_cnt_n   = '0;
                            state_n      = HUNT;
                        end else begin
                            bit_cnt_n = bit_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_rx_ctrl.sv
// tb_fsk_rx_ctrl
// Directed bench for fsk_rx_ctrl: calibration, spread reject, sync and
// framing, start/stop priority, edge-versus-saturation and carrier loss.
module tb_fsk_rx_ctrl;
    import fsk_pkg::*;

    logic        bb_clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        edge_evt;
    logic        bit_in;
    logic        bit_vld;
    logic [15:0] v_short;
    logic [15:0] v_long;
    logic        cal_done;
    logic        cal_err;
    logic        frame_sync;
    logic        pay_bit;
    logic        pay_vld;
    logic        frame_done;
    logic        carrier_lost;

    fsk_rx_ctrl dut (
        .bb_clk       (bb_clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .edge_evt     (edge_evt),
        .bit_in       (bit_in),
        .bit_vld      (bit_vld),
        .v_short      (v_short),
        .v_long       (v_long),
        .cal_done     (cal_done),
        .cal_err      (cal_err),
        .frame_sync   (frame_sync),
        .pay_bit      (pay_bit),
        .pay_vld      (pay_vld),
        .frame_done   (frame_done),
        .carrier_lost (carrier_lost)
    );

    always #5 bb_clk = ~bb_clk;

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    always @(posedge bb_clk) cyc++;

    // Pulse monitor, sampled on the falling edge away from the active edge.
    int   nCalErr     = 0;
    int   nSync       = 0;
    int   nLost       = 0;
    int   nFdone      = 0;
    int   payTotal    = 0;
    int   syncCyc     = -1;
    int   fdPayTotal  = -1;
    logic fdWithVld   = 1'b0;
    logic payLog [0:255];

    always @(negedge bb_clk) begin
        if (cal_err) nCalErr++;
        if (frame_sync) begin
            nSync++;
            syncCyc = cyc;
        end
        if (carrier_lost) nLost++;
        if (pay_vld) begin
            if (payTotal < 256) payLog[payTotal] = pay_bit;
            payTotal++;
        end
        if (frame_done) begin
            nFdone++;
            fdPayTotal = payTotal;
            fdWithVld  = pay_vld;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of inputs; every strobe is dropped again after the edge.
    task automatic applyStimulus(input logic e, input logic v, input logic b,
                                 input logic st, input logic sp);
        edge_evt = e;
        bit_vld  = v;
        bit_in   = b;
        start    = st;
        stop     = sp;
        @(posedge bb_clk);
        #1;
        edge_evt = 1'b0;
        bit_vld  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // An edge followed by gap quiet cycles: the next edge samples ic == gap.
    task automatic sendEdgeGap(input int gap);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(gap);
    endtask

    int lastBitCyc = 0;
    task automatic sendBit(input logic b);
        lastBitCyc = cyc;
        applyStimulus(1'b0, 1'b1, b, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic calibrate2040();
        for (int i = 0; i < 16; i++) sendEdgeGap((i % 2 == 0) ? 20 : 40);
    endtask

    initial begin
        logic [15:0] syncWord;
        logic [7:0]  prefix;
        logic [7:0]  pat;
        int          syncBase, payBase, fdBase, errBase, lostBase, waited;

        syncWord = 16'h2DD4;
        prefix   = 8'b1011_0010;
        pat      = 8'hA5;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        edge_evt = 1'b0; bit_in = 1'b0; bit_vld = 1'b0;
        repeat (3) @(posedge bb_clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_v_short", 32'(v_short), 32'h0000);
        checkOutput("rst_v_long", 32'(v_long), 32'hFFFF);
        checkOutput("rst_cal_done", 32'(cal_done), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        checkOutput("rst_pulses", 32'({cal_err, frame_sync, pay_vld, frame_done, carrier_lost}), 32'd0);

        $display("[TB] calibration 20/40");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        calibrate2040();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkOutput("cal_min", 32'(dut.u_stats.min_val), 32'd20);
        checkOutput("cal_max", 32'(dut.u_stats.max_val), 32'd40);
        checkOutput("cal_done", 32'(cal_done), 32'd1);
        checkOutput("cal_v_short", 32'(v_short), 32'd28);
        checkOutput("cal_v_long", 32'(v_long), 32'd32);
        checkOutput("cal_state", 32'(dut.state), 32'(HUNT));

        $display("[TB] sync and frame");
        syncBase = nSync; payBase = payTotal; fdBase = nFdone;
        for (int i = 7; i >= 0; i--) sendBit(prefix[i]);
        for (int i = 15; i >= 0; i--) sendBit(syncWord[i]);
        checkOutput("sync_count", 32'(nSync - syncBase), 32'd1);
        checkOutput("sync_latency", 32'(syncCyc), 32'(lastBitCyc + 1));
        checkOutput("lock_state", 32'(dut.state), 32'(LOCK));
        for (int i = 0; i < 64; i++) sendBit(pat[7 - (i % 8)]);
        idle(2);
        checkOutput("pay_count", 32'(payTotal - payBase), 32'd64);
        for (int i = 0; i < 64; i++)
            checkOutput($sformatf("pay_bit%0d", i), 32'(payLog[payBase + i]), 32'(pat[7 - (i % 8)]));
        checkOutput("fdone_count", 32'(nFdone - fdBase), 32'd1);
        checkOutput("fdone_at_64", 32'(fdPayTotal - payBase), 32'd64);
        checkOutput("fdone_with_vld", 32'(fdWithVld), 32'd1);
        checkOutput("frame_state", 32'(dut.state), 32'(HUNT));
        checkOutput("frame_cal_done", 32'(cal_done), 32'd1);

        $display("[TB] start ignored in HUNT, stop beats frame_sync");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        checkOutput("start_in_hunt", 32'(dut.state), 32'(HUNT));
        syncBase = nSync;
        for (int i = 15; i >= 1; i--) sendBit(syncWord[i]);
        applyStimulus(1'b0, 1'b1, syncWord[0], 1'b0, 1'b1);
        idle(3);
        checkOutput("stop_no_sync", 32'(nSync - syncBase), 32'd0);
        checkOutput("stop_state", 32'(dut.state), 32'(IDLE));
        checkOutput("stop_cal_done", 32'(cal_done), 32'd0);
        checkOutput("stop_v_short", 32'(v_short), 32'h0000);
        checkOutput("stop_v_long", 32'(v_long), 32'hFFFF);

        $display("[TB] spread reject");
        errBase = nCalErr;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) sendEdgeGap(30);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkOutput("err_count", 32'(nCalErr - errBase), 32'd1);
        checkOutput("err_cal_done", 32'(cal_done), 32'd0);
        checkOutput("err_state", 32'(dut.state), 32'(CAL_ARM));
        checkOutput("err_v_short", 32'(v_short), 32'h0000);
        checkOutput("err_v_long", 32'(v_long), 32'hFFFF);

        $display("[TB] edge coincident with saturation");
        lostBase = nLost;
        calibrate2040();
        sendEdgeGap(65535);
        checkOutput("sat_ic_at_edge", 32'(dut.u_stats.ic), 32'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_ic_restart", 32'(dut.u_stats.ic), 32'd0);
        idle(1);
        checkOutput("sat_ic_next", 32'(dut.u_stats.ic), 32'd1);
        checkOutput("sat_no_lost", 32'(nLost - lostBase), 32'd0);
        checkOutput("sat_state", 32'(dut.state), 32'(HUNT));
        checkOutput("sat_cal_done", 32'(cal_done), 32'd1);

        $display("[TB] carrier loss in LOCK");
        lostBase = nLost; fdBase = nFdone; payBase = payTotal;
        for (int i = 15; i >= 0; i--) sendBit(syncWord[i]);
        for (int i = 0; i < 10; i++) sendBit(pat[7 - (i % 8)]);
        checkOutput("loss_lock_state", 32'(dut.state), 32'(LOCK));
        waited = 0;
        while ((nLost == lostBase) && (waited < 70000)) begin
            idle(1);
            waited++;
        end
        idle(2);
        checkOutput("loss_count", 32'(nLost - lostBase), 32'd1);
        checkOutput("loss_no_fdone", 32'(nFdone - fdBase), 32'd0);
        checkOutput("loss_pay_count", 32'(payTotal - payBase), 32'd10);
        checkOutput("loss_cal_done", 32'(cal_done), 32'd0);
        checkOutput("loss_v_short", 32'(v_short), 32'h0000);
        checkOutput("loss_v_long", 32'(v_long), 32'hFFFF);
        checkOutput("loss_state", 32'(dut.state), 32'(CAL_ARM));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsk_rx_ctrl.md
Name: fsk_rx_ctrl

Overview:
- Receive-side controller that sequences the FSK demodulator.
- Measures edge-to-edge intervals during the preamble and derives the v_short/v_long thresholds.
- Drives those thresholds to the demodulator, then hunts for a sync word in the demodulated bit stream and frames the payload.
- Sits in the bb_clk domain between the edge front-end and the demodulator/packet logic.

Parameters:
- CAL_N, 16, number of complete intervals measured per calibration (2..255).
- MIN_SPREAD, 8, minimum (max-min) interval spread in cycles for a valid calibration.
- SYNC_W, 16, sync word width in bits.
- SYNC_WORD, 16'h2DD4, sync pattern, MSB received first.
- PAYLOAD_BITS, 64, bits framed after sync (1..65535).

Ports:
- bb_clk  in  1  baseband clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: leave IDLE and begin calibration.
- stop  in  1  pulse: return to IDLE from any state.
- edge_evt  in  1  one-cycle pulse per detected flag_bit edge, already in bb_clk domain.
- bit_in  in  1  demodulated bit.
- bit_vld  in  1  qualifies bit_in, one cycle per bit.
- v_short  out  16  short-interval threshold to the demodulator.
- v_long  out  16  long-interval threshold to the demodulator.
- cal_done  out  1  level: thresholds valid.
- cal_err  out  1  one-cycle pulse: calibration rejected (spread too small).
- frame_sync  out  1  one-cycle pulse on sync match.
- pay_bit  out  1  payload bit.
- pay_vld  out  1  qualifies pay_bit.
- frame_done  out  1  one-cycle pulse with the last payload bit.
- carrier_lost  out  1  one-cycle pulse on interval timeout.

Behaviour:
- Reset values:
  - state=IDLE, v_short=16'h0000, v_long=16'hFFFF (demodulator holds its output).
  - All pulses 0, cal_done=0; interval counter, min/max, shift register and bit counter cleared.
- Interval counter ic (16 b):
  - Cleared on edge_evt, otherwise +1.
  - Saturates at 16'hFFFF, no wrap.
  - The value sampled on edge_evt is the interval.
- States: IDLE, CAL_ARM, CAL, CALC, HUNT, LOCK.
- IDLE: start -> CAL_ARM. Other inputs are ignored.
- CAL_ARM: the first edge_evt starts a full interval and is discarded; -> CAL. Resets n=0, min=FFFF, max=0.
- CAL:
  - Each edge_evt updates min/max with ic and increments n.
  - When n reaches CAL_N -> CALC.
  - ic saturation -> carrier_lost pulse, -> CAL_ARM.
- CALC (one cycle):
  - spread=max-min.
  - If spread<MIN_SPREAD: cal_err pulse, -> CAL_ARM.
  - Otherwise:
    - mid = (min+max)>>1 using a 17-bit sum.
    - h = spread>>3.
    - v_short = mid-h; v_long = mid+h. No overflow is possible since min ≤ mid-h and mid+h ≤ max.
    - Register the outputs, set cal_done=1, -> HUNT.
  - Thresholds change only in CALC or on reset.
- HUNT:
  - On bit_vld, shift bit_in into the LSB of an SYNC_W-bit register.
  - A match requires at least SYNC_W bits shifted since entry. On the cycle of the SYNC_W-th valid bit, when register==SYNC_WORD, pulse frame_sync and -> LOCK.
  - Latency: frame_sync is asserted the cycle after the matching bit_vld.
- LOCK:
  - Each bit_vld gives pay_vld=1 and pay_bit=bit_in, registered with 1-cycle latency.
  - Bit counter counts to PAYLOAD_BITS; frame_done is asserted with the last pay_vld.
  - Then -> HUNT with the shift register cleared; cal_done stays 1.
- Timeout in HUNT/LOCK: ic saturation -> carrier_lost pulse, cal_done=0, v_short/v_long return to reset values, -> CAL_ARM. A partial frame is dropped with no frame_done.
- stop has priority over every transition except rst. From any state it goes to IDLE, clears cal_done and restores reset thresholds.
- start outside IDLE is ignored.
- edge_evt and saturation in the same cycle: the edge wins (ic cleared, no timeout).
- bit_vld in IDLE/CAL_ARM/CAL/CALC is ignored.
- rst mid-frame: immediate return to reset values, no pulses emitted.

Decomposition:
- Package fsk_pkg:
  - State enum.
  - IC_MAX = 16'hFFFF.
  - Reset threshold constants V_SHORT_RST and V_LONG_RST, shared with the demodulator bench.
- Sub-module fsk_interval_stats: saturating interval counter plus min/max/count tracker.
  - Inputs: clear, edge_evt.
  - Outputs: ic, min, max, n, sat.
- The FSM, threshold arithmetic and framer stay in fsk_rx_ctrl.

Test Plan:
1. Calibration: rst, start, then edges alternating intervals 20/40 for 17 edges (CAL_N=16). Required: cal_done=1, min=20, max=40, mid=30, h=2, v_short=28, v_long=32.
2. Spread reject: start, then 17 edges all at interval 30. Required: one cal_err pulse, cal_done=0, controller returns to CAL_ARM, thresholds remain 0/FFFF.
3. Sync and frame:
   - Stimulus: after calibration, feed 8 random bits, then 2DD4 MSB-first, then 64 bits of A5 repeated.
   - Required: frame_sync exactly once, one cycle after the final sync bit.
   - Required: 64 pay_vld with pattern 10100101.
   - Required: frame_done coincides with the 64th pay_vld, then the controller returns to HUNT.
4. Carrier loss: in LOCK after 10 payload bits, withhold edge_evt for 65535 cycles. Required: carrier_lost pulse, no frame_done, cal_done=0, thresholds back to 0/FFFF.
5. Stop/start priority: assert stop in the same cycle as frame_sync would fire. Required: IDLE, no frame_sync. A start pulse while in HUNT produces no state change.
6. Edge vs saturation: edge_evt coincides with ic reaching FFFF. Required: no carrier_lost, ic restarts from 0.
